// File: rtl/pc_branch_ctrl_if.sv
// Fetch-redirect bundle between the EX/jump logic (master) and the PC stage (slave).
// Carries redirect requests in and the fetch PC, flush and statistics out.
interface pc_branch_ctrl_if #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic             jump;
    logic             jump_cond_true;
    logic [PC_W-1:0]  jump_target;
    logic [PC_W-1:0]  pc;
    logic             flush;
    logic             redirect_taken;
    logic             misalign;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, jump, jump_cond_true, jump_target,
        input  pc, flush, redirect_taken, misalign, taken_cnt
    );

    modport slave (
        input  stall, jump, jump_cond_true, jump_target,
        output pc, flush, redirect_taken, misalign, taken_cnt
    );
endinterface

// File: rtl/pc_branch_ctrl.sv
// Program-counter and redirect stage: owns the fetch PC, turns jump requests into
// PC loads with a fixed-length wrong-path flush, and counts accepted redirects.
module pc_branch_ctrl #(
    parameter int unsigned      PC_W         = 32,
    parameter logic [PC_W-1:0]  RESET_PC     = '0,
    parameter int unsigned      INSTR_BYTES  = 4,
    parameter int unsigned      FLUSH_CYCLES = 2,
    parameter int unsigned      CNT_W        = 16
) (
    input logic              clk,
    input logic              rst_n,
    pc_branch_ctrl_if.slave  bus
);

    localparam logic [PC_W-1:0] LOW_MASK   = PC_W'(INSTR_BYTES - 1);
    localparam logic [PC_W-1:0] PC_INC     = PC_W'(INSTR_BYTES);
    localparam logic [3:0]      FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pend_tgt_q, pend_tgt_d;
    logic             pend_mis_q, pend_mis_d;
    logic             flush_q, flush_d;
    logic             redir_q, redir_d;
    logic             mis_q, mis_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] taken_q, taken_d;

    logic             req;
    logic [PC_W-1:0]  req_tgt;
    logic             req_mis;
    logic             accept;
    logic [PC_W-1:0]  acc_tgt;
    logic             acc_mis;
    logic [PC_W-1:0]  pc_next_seq;

    assign req = bus.jump | bus.jump_cond_true;

    // Target bits are gated by req so an undriven target bus never reaches state.
    assign req_tgt = req ? (bus.jump_target & ~LOW_MASK) : '0;
    assign req_mis = req & (|(bus.jump_target & LOW_MASK));

    assign pc_next_seq = pc_q + PC_INC;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        pend_mis_d = pend_mis_q;
        flush_d    = flush_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        acc_tgt    = req_tgt;
        acc_mis    = req_mis;

        unique case (state_q)
            ST_RUN: begin
                if (req) begin
                    if (bus.stall) begin
                        pend_tgt_d = req_tgt;
                        pend_mis_d = req_mis;
                        state_d    = ST_HOLD;
                    end else begin
                        accept = 1'b1;
                    end
                end else if (!bus.stall) begin
                    pc_d = pc_next_seq;
                end
            end

            ST_HOLD: begin
                // The first latched target wins; new requests are ignored here.
                if (!bus.stall) begin
                    accept  = 1'b1;
                    acc_tgt = pend_tgt_q;
                    acc_mis = pend_mis_q;
                end
            end

            ST_FLUSH: begin
                if (!bus.stall) begin
                    pc_d = pc_next_seq;
                    if (cnt_q == 4'd0) begin
                        flush_d = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end

            default: begin
                flush_d = 1'b0;
                state_d = ST_RUN;
            end
        endcase

        if (accept) begin
            pc_d    = acc_tgt;
            flush_d = 1'b1;
            cnt_d   = FLUSH_LAST;
            state_d = ST_FLUSH;
        end

        redir_d = accept;
        mis_d   = accept & acc_mis;

        // Saturating count: an all-ones counter simply stops.
        if (accept && (taken_q != '1)) begin
            taken_d = taken_q + CNT_W'(1);
        end else begin
            taken_d = taken_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            pend_mis_q <= 1'b0;
            flush_q    <= 1'b0;
            redir_q    <= 1'b0;
            mis_q      <= 1'b0;
            cnt_q      <= 4'd0;
            taken_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_mis_q <= pend_mis_d;
            flush_q    <= flush_d;
            redir_q    <= redir_d;
            mis_q      <= mis_d;
            cnt_q      <= cnt_d;
            taken_q    <= taken_d;
        end
    end

    assign bus.pc             = pc_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_taken = redir_q;
    assign bus.misalign       = mis_q;
    assign bus.taken_cnt      = taken_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Scoreboard bench for pc_branch_ctrl: a behavioural model predicts every cycle's
// outputs, a monitor compares; a second instance with a 2-bit counter checks saturation.
module tb_pc_branch_ctrl;

    localparam int unsigned PC_W         = 32;
    localparam int unsigned INSTR_BYTES  = 4;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam logic [31:0] RESET_PC     = 32'h0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pc_branch_ctrl_if #(.PC_W(PC_W), .CNT_W(16)) bus   ();
    pc_branch_ctrl_if #(.PC_W(PC_W), .CNT_W(2))  bus_s ();

    pc_branch_ctrl #(
        .PC_W(PC_W), .RESET_PC(RESET_PC), .INSTR_BYTES(INSTR_BYTES),
        .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    pc_branch_ctrl #(
        .PC_W(PC_W), .RESET_PC(RESET_PC), .INSTR_BYTES(INSTR_BYTES),
        .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_s.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        redir;
        logic        mis;
        logic [31:0] cnt16;
        logic [31:0] cnt2;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: redirect bookkeeping with plain integers.
    logic [31:0] m_pc;
    int          m_flush_left;
    bit          m_pend;
    logic [31:0] m_pend_tgt;
    bit          m_pend_mis;
    bit          m_redir;
    bit          m_mis;
    int          m_taken;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc         = RESET_PC;
        m_flush_left = 0;
        m_pend       = 1'b0;
        m_pend_tgt   = '0;
        m_pend_mis   = 1'b0;
        m_redir      = 1'b0;
        m_mis        = 1'b0;
        m_taken      = 0;
    endfunction

    function automatic void push_expect();
        exp_t e;
        e.pc    = m_pc;
        e.flush = (m_flush_left > 0);
        e.redir = m_redir;
        e.mis   = m_mis;
        e.cnt16 = (m_taken > 65535) ? 32'd65535 : 32'(m_taken);
        e.cnt2  = (m_taken > 3) ? 32'd3 : 32'(m_taken);
        exp_q.push_back(e);
    endfunction

    function automatic void model_step(input bit stall, input bit jump, input bit jc,
                                       input logic [31:0] tgt);
        bit          req     = jump | jc;
        bit          acc     = 1'b0;
        logic [31:0] aligned = (tgt / 32'(INSTR_BYTES)) * 32'(INSTR_BYTES);
        bit          low_set = (tgt % 32'(INSTR_BYTES)) != 0;
        logic [31:0] a_tgt   = '0;
        bit          a_mis   = 1'b0;
        m_redir = 1'b0;
        m_mis   = 1'b0;
        if (m_flush_left > 0) begin
            if (!stall) begin
                m_pc = m_pc + 32'(INSTR_BYTES);
                m_flush_left--;
            end
        end else if (m_pend) begin
            if (!stall) begin
                acc    = 1'b1;
                a_tgt  = m_pend_tgt;
                a_mis  = m_pend_mis;
                m_pend = 1'b0;
            end
        end else if (req) begin
            if (stall) begin
                m_pend     = 1'b1;
                m_pend_tgt = aligned;
                m_pend_mis = low_set;
            end else begin
                acc   = 1'b1;
                a_tgt = aligned;
                a_mis = low_set;
            end
        end else if (!stall) begin
            m_pc = m_pc + 32'(INSTR_BYTES);
        end
        if (acc) begin
            m_pc         = a_tgt;
            m_flush_left = FLUSH_CYCLES;
            m_redir      = 1'b1;
            m_mis        = a_mis;
            m_taken++;
        end
        push_expect();
    endfunction

    // Drive one cycle of stimulus on the falling edge and record the prediction.
    task automatic drive(input bit stall, input bit jump, input bit jc, input logic [31:0] tgt);
        @(negedge clk);
        rst_n = 1'b1;
        bus.stall            = stall;
        bus.jump             = jump;
        bus.jump_cond_true   = jc;
        bus.jump_target      = (jump | jc) ? tgt : 'x;
        bus_s.stall          = stall;
        bus_s.jump           = jump;
        bus_s.jump_cond_true = jc;
        bus_s.jump_target    = (jump | jc) ? tgt : 'x;
        model_step(stall, jump, jc, tgt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Reset asserted mid-cycle must clear outputs without waiting for a clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_flush", 32'(bus.flush), 32'd0);
        check("async_rst_pc", bus.pc, RESET_PC);
        check("async_rst_cnt", 32'(bus.taken_cnt), 32'd0);
        model_reset();
        push_expect();
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("pc", bus.pc, mon_e.pc);
                check("flush", 32'(bus.flush), 32'(mon_e.flush));
                check("redirect_taken", 32'(bus.redirect_taken), 32'(mon_e.redir));
                check("misalign", 32'(bus.misalign), 32'(mon_e.mis));
                check("taken_cnt", 32'(bus.taken_cnt), mon_e.cnt16);
                check("taken_cnt_sat", 32'(bus_s.taken_cnt), mon_e.cnt2);
            end
        end
    end

    initial begin : stimulus
        bus.stall = 1'b0; bus.jump = 1'b0; bus.jump_cond_true = 1'b0; bus.jump_target = '0;
        bus_s.stall = 1'b0; bus_s.jump = 1'b0; bus_s.jump_cond_true = 1'b0; bus_s.jump_target = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_pc", bus.pc, RESET_PC);
        check("reset_flush", 32'(bus.flush), 32'd0);
        check("reset_redirect", 32'(bus.redirect_taken), 32'd0);
        check("reset_misalign", 32'(bus.misalign), 32'd0);
        check("reset_cnt", 32'(bus.taken_cnt), 32'd0);

        // Sequential fetch after reset release.
        idle(3);
        // Conditional jump accepted while running.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        idle(3);
        // Stalled request parks in HOLD, then redirects once the stall drops.
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0040);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        idle(3);
        // Both request sources together with a misaligned target: one redirect.
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0203);
        idle(3);
        // Requests during FLUSH are ignored, and a stall stretches the flush.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0080);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0300);
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0300);
        idle(2);
        // Reset while flushing.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0500);
        async_reset();
        idle(2);

        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0,
                  ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 4095)));
            if (i == 400) async_reset();
        end
        // PC wrap around the top of the address space.
        drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8);
        idle(4);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
